// File: rtl/coco_irq_timer.sv
// GIME-style interrupt controller with a 12-bit interval timer at $FF92-$FF95.
// Everything is clocked on the falling edge of the CPU E clock; _irq/_firq are open-drain.
module coco_irq_timer #(
    parameter int TMR_WIDTH = 12,
    parameter int PRESCALE  = 1
) (
    input  logic        e,
    input  logic        _reset,
    input  logic        r_w_cpu,
    input  logic [15:0] address_cpu,
    input  logic [7:0]  data_in,
    input  logic [4:0]  irq_src,
    input  logic        irq_master,
    input  logic        firq_master,
    output logic [7:0]  data_out,
    output logic        data_oe,
    output wire         _irq,
    output wire         _firq
);
    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [5:0]           irq_en, firq_en, irq_pend, firq_pend, set;
    logic [4:0]           src_q;
    logic [TMR_WIDTH-1:0] reload, count;
    logic [PS_W-1:0]      psc;
    logic                 sel_ien, sel_fen, sel_msb, sel_lsb, hit;
    logic                 running, step, tick;

    assign sel_ien = (address_cpu == 16'hFF92);
    assign sel_fen = (address_cpu == 16'hFF93);
    assign sel_msb = (address_cpu == 16'hFF94);
    assign sel_lsb = (address_cpu == 16'hFF95);
    assign hit     = sel_ien | sel_fen | sel_msb | sel_lsb;

    assign running = |reload;
    assign step    = (psc == PS_W'(PRESCALE - 1));
    // A restart write owns the counter on its edge, so it can never tick alongside it.
    assign tick    = running & step & (count == TMR_WIDTH'(1)) & ~(~r_w_cpu & sel_msb);
    assign set     = {tick, irq_src & ~src_q};

    always_ff @(negedge e or negedge _reset) begin
        if (!_reset) begin
            reload <= '0;
            count  <= '0;
            psc    <= '0;
        end else begin
            if (!r_w_cpu && sel_lsb)
                reload[7:0] <= data_in;
            if (!r_w_cpu && sel_msb) begin
                reload[TMR_WIDTH-1:8] <= data_in[TMR_WIDTH-9:0];
                count <= {data_in[TMR_WIDTH-9:0], reload[7:0]};
                psc   <= '0;
            end else if (!running) begin
                count <= '0;
                psc   <= '0;
            end else begin
                psc <= step ? '0 : psc + PS_W'(1);
                // A count of 0 only occurs after an LSB-only load; treat it like the terminal count.
                if (step)
                    count <= (count <= TMR_WIDTH'(1)) ? reload : count - TMR_WIDTH'(1);
            end
        end
    end

    always_ff @(negedge e or negedge _reset) begin
        if (!_reset) begin
            irq_en    <= '0;
            firq_en   <= '0;
            irq_pend  <= '0;
            firq_pend <= '0;
            src_q     <= '0;
        end else begin
            src_q     <= irq_src;
            // Read-clear applies first so a same-edge set survives.
            irq_pend  <= ((r_w_cpu && sel_ien) ? 6'b0 : irq_pend)  | (set & irq_en);
            firq_pend <= ((r_w_cpu && sel_fen) ? 6'b0 : firq_pend) | (set & firq_en);
            if (!r_w_cpu && sel_ien)
                irq_en <= data_in[5:0];
            if (!r_w_cpu && sel_fen)
                firq_en <= data_in[5:0];
        end
    end

    always_comb begin
        data_out = 8'h00;
        data_oe  = r_w_cpu & hit;
        if (r_w_cpu) begin
            if (sel_ien)      data_out = {2'b00, irq_pend};
            else if (sel_fen) data_out = {2'b00, firq_pend};
            else if (sel_msb) data_out = 8'(reload[TMR_WIDTH-1:8]);
            else if (sel_lsb) data_out = reload[7:0];
        end
    end

    assign _irq  = (irq_master  & |irq_pend)  ? 1'b0 : 1'bz;
    assign _firq = (firq_master & |firq_pend) ? 1'b0 : 1'bz;
endmodule
